// File: rtl/zigbee_pad_mux.sv
// Pad-ring multiplexer for the zigbee platform: synchronises pad inputs, debounces
// the pad channel select and serialises the selected core channel as framed beats.
module zigbee_pad_mux #(
  parameter int IN_W        = 22,
  parameter int OUT_W       = 16,
  parameter int DATA_W      = 40,
  parameter int N_CH        = 4,
  parameter int SEL_W       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int SEL_HOLD    = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [IN_W-1:0]          pad_in_i,
  output logic [IN_W-1:0]          core_in_o,
  input  logic [SEL_W-1:0]         pad_sel_i,
  input  logic [N_CH*DATA_W-1:0]   ch_data_i,
  input  logic [N_CH-1:0]          ch_valid_i,
  output logic [N_CH-1:0]          ch_ready_o,
  output logic [OUT_W-1:0]         pad_out_o,
  output logic                     pad_valid_o,
  output logic                     pad_frame_o,
  output logic [SEL_W-1:0]         active_ch_o,
  output logic                     sel_chg_o
);

  localparam int NBEATS = (DATA_W + OUT_W - 1) / OUT_W;
  localparam int PAD_W  = NBEATS * OUT_W;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int CNT_W  = $clog2(SEL_HOLD + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // ------------------------------------------------------------------
  // Synchroniser chains for the data pads and the select pads
  // ------------------------------------------------------------------
  logic [IN_W-1:0]  in_sync_reg  [SYNC_STAGES];
  logic [SEL_W-1:0] sel_sync_reg [SYNC_STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i) begin
            in_sync_reg[gi]  <= '0;
            sel_sync_reg[gi] <= '0;
          end else begin
            in_sync_reg[gi]  <= pad_in_i;
            sel_sync_reg[gi] <= pad_sel_i;
          end
        end
      end else begin : g_rest
        always_ff @(posedge clk_i or posedge rst_i) begin
          if (rst_i) begin
            in_sync_reg[gi]  <= '0;
            sel_sync_reg[gi] <= '0;
          end else begin
            in_sync_reg[gi]  <= in_sync_reg[gi-1];
            sel_sync_reg[gi] <= sel_sync_reg[gi-1];
          end
        end
      end
    end
  endgenerate

  logic [SEL_W-1:0] sel_sync;
  assign core_in_o = in_sync_reg[SYNC_STAGES-1];
  assign sel_sync  = sel_sync_reg[SYNC_STAGES-1];

  // ------------------------------------------------------------------
  // Channel word views
  // ------------------------------------------------------------------
  logic [DATA_W-1:0] ch_word [N_CH];

  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_word
      assign ch_word[gi] = ch_data_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  logic [1:0]        state_reg,     state_next;
  logic [BEAT_W-1:0] beat_reg,      beat_next;
  logic [PAD_W-1:0]  word_reg,      word_next;
  logic [OUT_W-1:0]  pad_out_reg,   pad_out_next;
  logic              pad_valid_reg, pad_valid_next;
  logic              pad_frame_reg, pad_frame_next;
  logic [SEL_W-1:0]  active_reg,    active_next;
  logic              sel_chg_reg;
  logic [SEL_W-1:0]  cand_reg;
  logic [CNT_W-1:0]  cnt_reg,       cnt_next;

  // Beat 0 comes straight from the live channel; later beats from the captured copy.
  logic [OUT_W-1:0]  word_beat [NBEATS];

  generate
    for (gi = 0; gi < NBEATS; gi++) begin : g_beat
      assign word_beat[gi] = word_reg[gi*OUT_W +: OUT_W];
    end
  endgenerate

  logic [PAD_W-1:0]  active_pad;
  logic [BEAT_W-1:0] beat_inc;
  logic              sel_ignore;
  logic              commit;
  logic              idle_ready;
  logic              handshake;

  assign active_pad = PAD_W'(ch_word[active_reg]);
  assign beat_inc   = beat_reg + BEAT_W'(1);

  // ------------------------------------------------------------------
  // Select debounce: the counter tracks how long the candidate has been stable
  // ------------------------------------------------------------------
  always_comb begin
    sel_ignore = (int'(sel_sync) >= N_CH) || (sel_sync == active_reg);
    cnt_next   = cnt_reg;
    if (sel_ignore) begin
      cnt_next = '0;
    end else if (sel_sync != cand_reg) begin
      cnt_next = CNT_W'(1);
    end else if (cnt_reg != CNT_W'(SEL_HOLD)) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  assign commit     = (state_reg == ST_IDLE) && (cnt_reg == CNT_W'(SEL_HOLD)) &&
                      (cand_reg != active_reg);
  assign idle_ready = (state_reg == ST_IDLE) && !commit && !rst_i;
  assign handshake  = idle_ready && ch_valid_i[active_reg];
  assign active_next = commit ? cand_reg : active_reg;

  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ready
      assign ch_ready_o[gi] = idle_ready && (active_reg == SEL_W'(gi));
    end
  endgenerate

  // ------------------------------------------------------------------
  // Framing FSM
  // ------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    beat_next      = beat_reg;
    word_next      = word_reg;
    pad_out_next   = '0;
    pad_valid_next = 1'b0;
    pad_frame_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (handshake) begin
          word_next      = active_pad;
          pad_out_next   = active_pad[OUT_W-1:0];
          pad_valid_next = 1'b1;
          pad_frame_next = 1'b1;
          beat_next      = '0;
          state_next     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (beat_reg == BEAT_W'(NBEATS - 1)) begin
          state_next = ST_GAP;
        end else begin
          beat_next      = beat_inc;
          pad_out_next   = word_beat[beat_inc];
          pad_valid_next = 1'b1;
        end
      end
      ST_GAP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      beat_reg      <= '0;
      word_reg      <= '0;
      pad_out_reg   <= '0;
      pad_valid_reg <= 1'b0;
      pad_frame_reg <= 1'b0;
      active_reg    <= '0;
      sel_chg_reg   <= 1'b0;
      cand_reg      <= '0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      beat_reg      <= beat_next;
      word_reg      <= word_next;
      pad_out_reg   <= pad_out_next;
      pad_valid_reg <= pad_valid_next;
      pad_frame_reg <= pad_frame_next;
      active_reg    <= active_next;
      sel_chg_reg   <= commit;
      cand_reg      <= sel_sync;
      cnt_reg       <= cnt_next;
    end
  end

  assign pad_out_o   = pad_out_reg;
  assign pad_valid_o = pad_valid_reg;
  assign pad_frame_o = pad_frame_reg;
  assign active_ch_o = active_reg;
  assign sel_chg_o   = sel_chg_reg;

endmodule

// File: tb/tb_zigbee_pad_mux.sv
// Directed bench for zigbee_pad_mux: default build plus an N_CH=3 build for
// out-of-range select handling.
module tb_zigbee_pad_mux;

  logic          clk;
  logic          rst;
  logic [21:0]   pad_in;
  logic [21:0]   core_in;
  logic [1:0]    pad_sel;
  logic [159:0]  ch_data;
  logic [3:0]    ch_valid;
  logic [3:0]    ch_ready;
  logic [15:0]   pad_out;
  logic          pad_valid;
  logic          pad_frame;
  logic [1:0]    active_ch;
  logic          sel_chg;

  logic [21:0]   core_in3;
  logic [1:0]    pad_sel3;
  logic [119:0]  ch_data3;
  logic [2:0]    ch_valid3;
  logic [2:0]    ch_ready3;
  logic [15:0]   pad_out3;
  logic          pad_valid3;
  logic          pad_frame3;
  logic [1:0]    active_ch3;
  logic          sel_chg3;

  int checks = 0;
  int errors = 0;

  zigbee_pad_mux u_dut (
    .clk_i(clk), .rst_i(rst), .pad_in_i(pad_in), .core_in_o(core_in),
    .pad_sel_i(pad_sel), .ch_data_i(ch_data), .ch_valid_i(ch_valid),
    .ch_ready_o(ch_ready), .pad_out_o(pad_out), .pad_valid_o(pad_valid),
    .pad_frame_o(pad_frame), .active_ch_o(active_ch), .sel_chg_o(sel_chg)
  );

  zigbee_pad_mux #(.N_CH(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .pad_in_i(pad_in), .core_in_o(core_in3),
    .pad_sel_i(pad_sel3), .ch_data_i(ch_data3), .ch_valid_i(ch_valid3),
    .ch_ready_o(ch_ready3), .pad_out_o(pad_out3), .pad_valid_o(pad_valid3),
    .pad_frame_o(pad_frame3), .active_ch_o(active_ch3), .sel_chg_o(sel_chg3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; pad_in = '0; pad_sel = '0; ch_data = '0; ch_valid = '0;
    pad_sel3 = '0; ch_data3 = '0; ch_valid3 = '0;
    tick(); tick();
    chk("rst_ready", 64'(ch_ready), 64'h0);
    chk("rst_valid", 64'(pad_valid), 64'h0);
    rst = 1'b0;
    tick();
    chk("rel_ready", 64'(ch_ready), 64'h1);
    chk("rel_active", 64'(active_ch), 64'h0);
    chk("rel_chg", 64'(sel_chg), 64'h0);
    chk("rel_core_in", 64'(core_in), 64'h0);

    // N_CH=3 build: select 3 is out of range and must never commit
    pad_sel3 = 2'd3;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("n3_active_hold", 64'(active_ch3), 64'h0);
      chk("n3_no_chg", 64'(sel_chg3), 64'h0);
    end
    pad_sel3 = 2'd2;
    for (int k = 0; k < 6; k++) tick();
    chk("n3_pre_commit", 64'(active_ch3), 64'h0);
    tick();
    chk("n3_commit", 64'(active_ch3), 64'h2);
    chk("n3_chg", 64'(sel_chg3), 64'h1);

    // Input synchroniser latency
    pad_in = 22'h2AAAAA;
    tick();
    chk("sync_edge1", 64'(core_in), 64'h0);
    tick();
    chk("sync_edge2", 64'(core_in), 64'h2AAAAA);

    // Serialise a 40-bit word on channel 0
    ch_data[39:0] = 40'hAB_CDEF_1234;
    ch_valid = 4'b0001;
    chk("hs_ready", 64'(ch_ready), 64'h1);
    tick();
    ch_valid = 4'b0000;
    ch_data[39:0] = 40'h55_5555_5555;
    chk("beat0_data", 64'(pad_out), 64'h1234);
    chk("beat0_frame", 64'(pad_frame), 64'h1);
    chk("beat0_valid", 64'(pad_valid), 64'h1);
    chk("send_ready", 64'(ch_ready), 64'h0);
    tick();
    chk("beat1_data", 64'(pad_out), 64'hCDEF);
    chk("beat1_frame", 64'(pad_frame), 64'h0);
    tick();
    chk("beat2_data", 64'(pad_out), 64'h00AB);
    chk("beat2_valid", 64'(pad_valid), 64'h1);
    tick();
    chk("gap_valid", 64'(pad_valid), 64'h0);
    chk("gap_data", 64'(pad_out), 64'h0);
    chk("gap_ready", 64'(ch_ready), 64'h0);
    tick();
    chk("idle_ready", 64'(ch_ready), 64'h1);

    // Valid on a non-active channel is ignored
    ch_valid = 4'b0010;
    tick();
    chk("other_ch_ignored", 64'(pad_valid), 64'h0);
    ch_valid = 4'b0000;

    // Debounce: synced select 1 for three cycles, then 2 held
    pad_sel = 2'd1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 3) pad_sel = 2'd2;
      chk("deb_active_hold", 64'(active_ch), 64'h0);
      chk("deb_no_chg", 64'(sel_chg), 64'h0);
    end
    chk("commit_ready_low", 64'(ch_ready), 64'h0);
    tick();
    chk("deb_active", 64'(active_ch), 64'h2);
    chk("deb_chg", 64'(sel_chg), 64'h1);
    chk("deb_ready", 64'(ch_ready), 64'h4);
    pad_sel = 2'd3;
    tick();
    chk("deb_chg_single", 64'(sel_chg), 64'h0);

    // Select change during SEND: commit deferred to return to IDLE
    tick();
    ch_data[119:80] = 40'h12_3456_789A;
    ch_valid = 4'b0100;
    chk("s5_hs_ready", 64'(ch_ready), 64'h4);
    tick();
    chk("s5_beat0", 64'(pad_out), 64'h789A);
    chk("s5_frame", 64'(pad_frame), 64'h1);
    tick();
    chk("s5_beat1", 64'(pad_out), 64'h3456);
    tick();
    chk("s5_beat2", 64'(pad_out), 64'h0012);
    tick();
    chk("s5_gap_valid", 64'(pad_valid), 64'h0);
    chk("s5_gap_active", 64'(active_ch), 64'h2);
    tick();
    chk("s5_commit_ready", 64'(ch_ready), 64'h0);
    chk("s5_commit_active", 64'(active_ch), 64'h2);
    tick();
    chk("s5_no_capture", 64'(pad_valid), 64'h0);
    chk("s5_active", 64'(active_ch), 64'h3);
    chk("s5_chg", 64'(sel_chg), 64'h1);
    chk("s5_ready", 64'(ch_ready), 64'h8);
    tick();
    chk("s5_still_idle", 64'(pad_valid), 64'h0);
    chk("s5_chg_single", 64'(sel_chg), 64'h0);

    // Reset during SEND beat 1
    ch_valid = 4'b1000;
    ch_data[159:120] = 40'hFF_FFFF_FFFF;
    tick();
    ch_valid = 4'b0000;
    chk("r_beat0", 64'(pad_out), 64'hFFFF);
    tick();
    chk("r_beat1", 64'(pad_valid), 64'h1);
    rst = 1'b1;
    pad_sel = 2'd0;
    #1;
    chk("r_out", 64'(pad_out), 64'h0);
    chk("r_valid", 64'(pad_valid), 64'h0);
    chk("r_frame", 64'(pad_frame), 64'h0);
    chk("r_active", 64'(active_ch), 64'h0);
    chk("r_ready", 64'(ch_ready), 64'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("r_rel_ready", 64'(ch_ready), 64'h1);
    chk("r_rel_active", 64'(active_ch), 64'h0);
    chk("r_rel_valid", 64'(pad_valid), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
